// File: rtl/dsp_accum_out_pkg.sv
// dsp_accum_out_pkg: shared types, default widths and round/saturate helper for the accumulator output stage
package dsp_accum_out_pkg;
  localparam int DEF_IN_W = 38;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 12;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam logic signed [DEF_IN_W:0] MAX_OUT = (DEF_IN_W+1)'(2**(DEF_OUT_W-1)-1);
  localparam logic signed [DEF_IN_W:0] MIN_OUT = (DEF_IN_W+1)'(-(2**(DEF_OUT_W-1)));
  typedef enum logic [1:0] {S_ACCUM, S_SAT, S_CLR} state_t;
  function automatic logic [DEF_OUT_W-1:0] sat_round(input logic signed [DEF_IN_W:0] v);
    return v > MAX_OUT ? MAX_OUT[DEF_OUT_W-1:0] : v < MIN_OUT ? MIN_OUT[DEF_OUT_W-1:0] : v[DEF_OUT_W-1:0];
  endfunction
endpackage

// File: rtl/dsp_accum_out_fifo.sv
// dsp_accum_out_fifo: first-word-fall-through FIFO that holds the last popped word when empty
module dsp_accum_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data_out = empty ? last_q : mem[rd_ptr];
  // storage, wrapping pointers and occupancy; a full FIFO may push when the head leaves in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/dsp_accum_round_sat_out.sv
// dsp_accum_round_sat_out: frame-counted capture, round/saturate and FIFO output of a MAC accumulator (optional DSP_ACC_SAT_FLAG_EN sticky overflow flag)
module dsp_accum_round_sat_out
  import dsp_accum_out_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  acc_i,
  input  logic             acc_vld_i,
  output logic             acc_clr_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             drop_o,
  output logic             overflow_o
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic signed [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT-1);
  state_t state;
  logic [CW-1:0] cnt;
  logic signed [IN_W:0] sum, rnd_q;
  logic [OUT_W-1:0] sat_v;
  logic push, pop, full, empty, clip;
  assign sum = $signed({acc_i[IN_W-1], acc_i}) + RND;
  assign sat_v = sat_round(rnd_q);
  assign clip = rnd_q > MAX_OUT || rnd_q < MIN_OUT;
  assign push = state == S_SAT;
  assign pop = out_valid_o && out_ready_i;
  assign out_valid_o = !empty;
  // frame FSM: count valid updates, capture the rounded sum on the last one, then push and request a clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_ACCUM;
      cnt <= '0;
      rnd_q <= '0;
      acc_clr_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      acc_clr_o <= state == S_SAT;
      drop_o <= push && full && !pop;
      case (state)
        S_ACCUM:
          if (acc_vld_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(FRAME_LEN-1)) begin
              rnd_q <= sum >>> SHIFT;
              state <= S_SAT;
            end
          end
        S_SAT: state <= S_CLR;
        default: begin
          cnt <= '0;
          state <= S_ACCUM;
        end
      endcase
    end
`ifdef DSP_ACC_SAT_FLAG_EN
  // sticky clip flag, set even when the clipped sample is dropped
  always_ff @(posedge clk or posedge reset)
    if (reset) overflow_o <= 1'b0;
    else if (push && clip) overflow_o <= 1'b1;
`else
  assign overflow_o = 1'b0;
  logic unused_clip;
  assign unused_clip = clip;
`endif
  dsp_accum_out_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst(reset),
    .data_in(sat_v),
    .push(push),
    .pop(pop),
    .data_out(out_data_o),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_dsp_accum_round_sat_out.sv
// tb_dsp_accum_round_sat_out: directed and random checks of the accumulator output stage against a queue model
module tb_dsp_accum_round_sat_out;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic acc_vld_i = 1'b0;
  logic out_ready_i = 1'b0;
  logic [37:0] acc_i = '0;
  logic acc_clr_o, out_valid_o, drop_o, overflow_o;
  logic [15:0] out_data_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] q[$];
  logic [15:0] last = '0;
  logic [15:0] pend = '0;
  int n = 0;
  int blind = 0;
  bit ovf = 0, pend_clip = 0, e_clr = 0, e_drop = 0;

  always #5 clk = ~clk;

  dsp_accum_round_sat_out dut (
    .clk(clk),
    .reset(reset),
    .acc_i(acc_i),
    .acc_vld_i(acc_vld_i),
    .acc_clr_o(acc_clr_o),
    .out_data_o(out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .drop_o(drop_o),
    .overflow_o(overflow_o)
  );

  function automatic longint rand_acc();
    int unsigned k = $urandom_range(0, 3);
    if (k == 0) return longint'(int'($urandom_range(0, 400000))) - 200000;
    if (k == 1) return 64'sd134215680 + longint'(int'($urandom_range(0, 8192))) - 4096;
    if (k == 2) return -64'sd134219776 + longint'(int'($urandom_range(0, 8192))) - 4096;
    return $signed({$urandom(), $urandom()}) >>> 26;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", out_valid_o, q.size() > 0);
    chk("data", out_data_o, q.size() > 0 ? q[0] : last);
    chk("clr", acc_clr_o, e_clr);
    chk("drop", drop_o, e_drop);
`ifdef DSP_ACC_SAT_FLAG_EN
    chk("ovf", overflow_o, ovf);
`else
    chk("ovf", overflow_o, 1'b0);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    last = '0;
    n = 0;
    blind = 0;
    ovf = 0;
    e_clr = 0;
    e_drop = 0;
  endtask

  task automatic step(input longint a, input bit v, input bit r);
    longint x;
    acc_i = a[37:0];
    acc_vld_i = v;
    out_ready_i = r;
    @(posedge clk);
    e_clr = 0;
    e_drop = 0;
    if (r && q.size() > 0) last = q.pop_front();
    if (blind == 2) begin
      e_clr = 1;
      if (q.size() < 4) q.push_back(pend);
      else e_drop = 1;
      if (pend_clip) ovf = 1;
    end
    if (blind > 0) blind--;
    else if (v) begin
      n++;
      if (n == 8) begin
        n = 0;
        blind = 2;
        x = (a + 2048) >>> 12;
        pend_clip = x > 32767 || x < -32768;
        pend = 16'(x > 32767 ? 32767 : x < -32768 ? -32768 : x);
      end
    end
    #1 check_all();
  endtask

  task automatic frame(input longint a, input bit r, input bit r1);
    for (int i = 0; i < 7; i++) step(rand_acc(), 1'b1, r);
    step(a, 1'b1, r);
    step(rand_acc(), 1'b1, r1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_all();
    reset = 1'b0;
    frame(6144, 0, 0);
    chk("rnd_pos", out_data_o, 16'd2);
    chk("clr_pulse", acc_clr_o, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("clr_once", acc_clr_o, 1'b0);
    frame(-6144, 0, 0);
    chk("rnd_neg", out_data_o, 16'hffff);
    step(0, 1'b0, 1'b1);
    frame(4095, 0, 0);
    chk("rnd_4095", out_data_o, 16'd1);
    step(0, 1'b0, 1'b1);
    frame(longint'(1) <<< 30, 0, 0);
    chk("sat_pos", out_data_o, 16'h7fff);
`ifdef DSP_ACC_SAT_FLAG_EN
    chk("ovf_set", overflow_o, 1'b1);
`else
    chk("ovf_off", overflow_o, 1'b0);
`endif
    step(0, 1'b0, 1'b1);
    frame(-(longint'(1) <<< 30), 0, 0);
    chk("sat_neg", out_data_o, 16'h8000);
    step(0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      frame(k * 4096, 0, 0);
      if (k == 5) chk("drop_full", drop_o, 1'b1);
      step(0, 1'b0, 1'b0);
    end
    for (int k = 1; k <= 4; k++) begin
      chk("drain", out_data_o, 16'(k));
      step(0, 1'b0, 1'b1);
    end
    chk("drained", out_valid_o, 1'b0);
    for (int k = 10; k <= 13; k++) begin
      frame(k * 4096, 0, 0);
      step(0, 1'b0, 1'b0);
    end
    frame(14 * 4096, 0, 1);
    chk("conc_nodrop", drop_o, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int k = 11; k <= 14; k++) begin
      chk("conc_order", out_data_o, 16'(k));
      step(0, 1'b0, 1'b1);
    end
    chk("conc_count", out_valid_o, 1'b0);
    frame(5 * 4096, 0, 0);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(rand_acc(), 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_data", out_data_o, 16'd0);
    chk("rst_clr", acc_clr_o, 1'b0);
    chk("rst_drop", drop_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step(rand_acc(), 1'b1, 1'b1);
    chk("fresh7", out_valid_o, 1'b0);
    step(7 * 4096, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0);
    chk("fresh8", out_valid_o, 1'b1);
    chk("fresh8_data", out_data_o, 16'd7);
    step(0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(i == 14 ? 3 * 4096 : rand_acc(), i % 2 == 0, 1'b0);
    step(0, 1'b1, 1'b0);
    chk("gap_data", out_data_o, 16'd3);
    step(0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(rand_acc(), 1'b1, 1'b1);
    chk("gap_ignored", out_valid_o, 1'b0);
    step(9 * 4096, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0);
    chk("gap_next", out_data_o, 16'd9);
    for (int i = 0; i < 1500; i++) step(rand_acc(), $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
